// File: rtl/pulse_sync_4bit.sv
// Four-bit event word synchronizer: captures a nonzero word, passes a toggle
// request through a two-flop chain plus an edge-detect flop, then emits the word as a one-cycle pulse.
module pulse_sync_4bit (
  input  logic       clk,
  input  logic       rst,
  input  logic [3:0] sig_4bit,
  output logic [3:0] sig_sync_4bit,
  output logic       busy
);

  logic [3:0] data_hold_q, data_hold_d;
  logic       req_tgl_q, req_tgl_d;
  logic       sync1_q, sync2_q, sync3_q;
  logic       busy_q, busy_d;
  logic [3:0] sig_sync_q, sig_sync_d;

  logic capture;
  logic req_edge;

  assign capture  = (sig_4bit != 4'h0) && !busy_q;
  assign req_edge = sync2_q ^ sync3_q;

  always_comb begin
    data_hold_d = data_hold_q;
    req_tgl_d   = req_tgl_q;
    busy_d      = busy_q;
    sig_sync_d  = 4'h0;

    if (capture) begin
      data_hold_d = sig_4bit;
      req_tgl_d   = ~req_tgl_q;
      busy_d      = 1'b1;
    end

    // Edge only occurs while busy is set, so it never coincides with a capture.
    if (req_edge) begin
      sig_sync_d = data_hold_q;
      busy_d     = 1'b0;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      data_hold_q <= 4'h0;
      req_tgl_q   <= 1'b0;
      sync1_q     <= 1'b0;
      sync2_q     <= 1'b0;
      sync3_q     <= 1'b0;
      busy_q      <= 1'b0;
      sig_sync_q  <= 4'h0;
    end else begin
      data_hold_q <= data_hold_d;
      req_tgl_q   <= req_tgl_d;
      sync1_q     <= req_tgl_q;
      sync2_q     <= sync1_q;
      sync3_q     <= sync2_q;
      busy_q      <= busy_d;
      sig_sync_q  <= sig_sync_d;
    end
  end

  assign sig_sync_4bit = sig_sync_q;
  assign busy          = busy_q;

endmodule

// File: tb/tb_pulse_sync_4bit.sv
// Bench for pulse_sync_4bit: a transfer-countdown reference model checked every
// cycle, plus directed vectors with hand-computed expectations.
module tb_pulse_sync_4bit;

  logic       clk = 1'b0;
  logic       rst = 1'b0;
  logic [3:0] sig_4bit = 4'h0;
  logic [3:0] sig_sync_4bit;
  logic       busy;

  int errors = 0;
  int checks = 0;

  pulse_sync_4bit dut (
    .clk           (clk),
    .rst           (rst),
    .sig_4bit      (sig_4bit),
    .sig_sync_4bit (sig_sync_4bit),
    .busy          (busy)
  );

  always #5 clk = ~clk;

  // Reference model: a transfer lasts 3 cycles after capture; the word
  // appears on the output on the edge where the remaining count runs out.
  int         m_cnt = 0;
  logic [3:0] m_hold = 4'h0;
  logic [3:0] exp_out = 4'h0;
  bit         model_valid = 0;

  always @(posedge clk) begin
    if (!rst) begin
      m_cnt       = 0;
      m_hold      = 4'h0;
      exp_out     = 4'h0;
      model_valid = 1;
    end else begin
      exp_out = (m_cnt == 1) ? m_hold : 4'h0;
      if (m_cnt == 0 && sig_4bit != 4'h0) begin
        m_hold = sig_4bit;
        m_cnt  = 3;
      end else if (m_cnt > 0) begin
        m_cnt = m_cnt - 1;
      end
    end
  end

  always @(negedge clk) begin
    if (model_valid) begin
      checks++;
      if (busy !== (m_cnt != 0)) begin
        errors++;
        $display("FAIL model_busy t=%0t got=%b exp=%b", $time, busy, (m_cnt != 0));
      end
      checks++;
      if (sig_sync_4bit !== exp_out) begin
        errors++;
        $display("FAIL model_out t=%0t got=%h exp=%h", $time, sig_sync_4bit, exp_out);
      end
    end
  end

  task automatic apply(input logic r, input logic [3:0] s);
    @(negedge clk);
    rst      = r;
    sig_4bit = s;
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string name, input logic exp_b, input logic [3:0] exp_o);
    checks++;
    if (busy !== exp_b || sig_sync_4bit !== exp_o) begin
      errors++;
      $display("FAIL %s t=%0t got busy=%b out=%h exp busy=%b out=%h",
               name, $time, busy, sig_sync_4bit, exp_b, exp_o);
    end
  endtask

  initial begin
    // Reset with input asserted
    apply(1'b0, 4'hF); chk("rst_c1", 1'b0, 4'h0);
    apply(1'b0, 4'hF); chk("rst_c2", 1'b0, 4'h0);
    apply(1'b1, 4'h0); chk("rst_rel1", 1'b0, 4'h0);
    apply(1'b1, 4'h0); chk("rst_rel2", 1'b0, 4'h0);

    // Single event
    apply(1'b1, 4'h6); chk("single_e0", 1'b1, 4'h0);
    apply(1'b1, 4'h0); chk("single_e1", 1'b1, 4'h0);
    apply(1'b1, 4'h0); chk("single_e2", 1'b1, 4'h0);
    apply(1'b1, 4'h0); chk("single_e3", 1'b0, 4'h6);
    apply(1'b1, 4'h0); chk("single_e4", 1'b0, 4'h0);

    // Drop while busy
    apply(1'b1, 4'h6); chk("drop_e0", 1'b1, 4'h0);
    apply(1'b1, 4'h9); chk("drop_e1", 1'b1, 4'h0);
    apply(1'b1, 4'h0); chk("drop_e2", 1'b1, 4'h0);
    apply(1'b1, 4'h0); chk("drop_e3", 1'b0, 4'h6);
    apply(1'b1, 4'h0); chk("drop_e4", 1'b0, 4'h0);
    apply(1'b1, 4'h0); chk("drop_e5", 1'b0, 4'h0);
    apply(1'b1, 4'h0); chk("drop_e6", 1'b0, 4'h0);
    apply(1'b1, 4'h0); chk("drop_e7", 1'b0, 4'h0);

    // Back-to-back identical data
    apply(1'b1, 4'hA); chk("b2b_e0", 1'b1, 4'h0);
    apply(1'b1, 4'h0); chk("b2b_e1", 1'b1, 4'h0);
    apply(1'b1, 4'h0); chk("b2b_e2", 1'b1, 4'h0);
    apply(1'b1, 4'h0); chk("b2b_e3", 1'b0, 4'hA);
    apply(1'b1, 4'hA); chk("b2b_e4", 1'b1, 4'h0);
    apply(1'b1, 4'h0); chk("b2b_e5", 1'b1, 4'h0);
    apply(1'b1, 4'h0); chk("b2b_e6", 1'b1, 4'h0);
    apply(1'b1, 4'h0); chk("b2b_e7", 1'b0, 4'hA);
    apply(1'b1, 4'h0); chk("b2b_e8", 1'b0, 4'h0);

    // Event presented at E3 is dropped
    apply(1'b1, 4'h2); chk("e3drop_e0", 1'b1, 4'h0);
    apply(1'b1, 4'h0); chk("e3drop_e1", 1'b1, 4'h0);
    apply(1'b1, 4'h0); chk("e3drop_e2", 1'b1, 4'h0);
    apply(1'b1, 4'hC); chk("e3drop_e3", 1'b0, 4'h2);
    apply(1'b1, 4'h0); chk("e3drop_e4", 1'b0, 4'h0);
    for (int i = 0; i < 4; i++) begin
      apply(1'b1, 4'h0); chk("e3drop_quiet", 1'b0, 4'h0);
    end

    // Reset mid-transfer, then a fresh event right after release
    apply(1'b1, 4'h3); chk("midrst_e0", 1'b1, 4'h0);
    apply(1'b1, 4'h0); chk("midrst_e1", 1'b1, 4'h0);
    apply(1'b0, 4'h0); chk("midrst_e2", 1'b0, 4'h0);
    apply(1'b1, 4'h5); chk("midrst_new_e0", 1'b1, 4'h0);
    apply(1'b1, 4'h0); chk("midrst_new_e1", 1'b1, 4'h0);
    apply(1'b1, 4'h0); chk("midrst_new_e2", 1'b1, 4'h0);
    apply(1'b1, 4'h0); chk("midrst_new_e3", 1'b0, 4'h5);
    apply(1'b1, 4'h0); chk("midrst_new_e4", 1'b0, 4'h0);

    // All bits set
    apply(1'b1, 4'hF); chk("allf_e0", 1'b1, 4'h0);
    apply(1'b1, 4'h0); chk("allf_e1", 1'b1, 4'h0);
    apply(1'b1, 4'h0); chk("allf_e2", 1'b1, 4'h0);
    apply(1'b1, 4'h0); chk("allf_e3", 1'b0, 4'hF);

    // Zero held for 10 cycles
    for (int i = 0; i < 10; i++) begin
      apply(1'b1, 4'h0); chk("zero_hold", 1'b0, 4'h0);
    end

    // Input held nonzero re-triggers every 4 cycles
    apply(1'b1, 4'h7); chk("hold_e0", 1'b1, 4'h0);
    apply(1'b1, 4'h7); chk("hold_e1", 1'b1, 4'h0);
    apply(1'b1, 4'h7); chk("hold_e2", 1'b1, 4'h0);
    apply(1'b1, 4'h7); chk("hold_e3", 1'b0, 4'h7);
    apply(1'b1, 4'h7); chk("hold_e4", 1'b1, 4'h0);
    apply(1'b1, 4'h0); chk("hold_e5", 1'b1, 4'h0);
    apply(1'b1, 4'h0); chk("hold_e6", 1'b1, 4'h0);
    apply(1'b1, 4'h0); chk("hold_e7", 1'b0, 4'h7);
    apply(1'b1, 4'h0); chk("hold_e8", 1'b0, 4'h0);

    @(negedge clk);
    #1;
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
